// File: rtl/paralelo_serial_pkg.sv
// Shared constants for the paralelo_serial transmit stage and its FIFO.
package paralelo_serial_pkg;
    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = 3;

    localparam logic [BYTE_W-1:0]    COMMA_BC    = 8'hBC;
    localparam logic [BIT_CNT_W-1:0] BIT_LAST    = 3'd7;
    localparam logic [0:0]           ST_PREAMBLE = 1'b0;
    localparam logic [0:0]           ST_RUN      = 1'b1;
endpackage

// File: rtl/fifo_2x8.sv
// Two-entry, byte-wide FIFO; a pop and a push in the same cycle are both honoured even when full.
module fifo_2x8
    import paralelo_serial_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [BYTE_W-1:0] wdata_i,
    output logic [BYTE_W-1:0] rdata_o,
    output logic [1:0]        count_o
);
    logic [BYTE_W-1:0] mem_q [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              do_pop_s, do_push_s;

    always_comb begin
        do_pop_s  = pop_i && (count_q != 2'd0);
        do_push_s = push_i && ((count_q != 2'd2) || do_pop_s);
        rd_ptr_d  = rd_ptr_q ^ do_pop_s;
        wr_ptr_d  = wr_ptr_q ^ do_push_s;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/paralelo_serial.sv
// Byte-to-serial transmitter, MSB first, filling idle slots with the comma byte 0xBC.
// Define PARALELO_SERIAL_PREAMBLE_EN to force PREAMBLE_BC comma bytes after every reset.
module paralelo_serial
    import paralelo_serial_pkg::*;
#(
    parameter int PREAMBLE_BC = 4
) (
    input  logic              clk_32f,
    input  logic              reset_L,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              data_out,
    output logic              valid_out,
    output logic              frame_out
);
    if ((PREAMBLE_BC < 1) || (PREAMBLE_BC > 7)) begin : g_bad_preamble
        $error("PREAMBLE_BC must be in 1..7");
    end

    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]    shreg_q, shreg_d;
    logic                 valid_q, valid_d;
    logic                 load_s, pop_s, push_s, ready_s, payload_ok_s;
    logic [BYTE_W-1:0]    fifo_rdata_s;
    logic [1:0]           fifo_count_s;

    assign load_s = (bit_cnt_q == BIT_LAST);

`ifdef PARALELO_SERIAL_PREAMBLE_EN
    localparam logic [BIT_CNT_W-1:0] PRE_TARGET = BIT_CNT_W'(PREAMBLE_BC);

    logic [BIT_CNT_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [0:0]           state_q, state_d;

    // The load that completes the last preamble comma may already carry payload.
    always_comb begin
        payload_ok_s = (state_q == ST_RUN) || ((pre_cnt_q + 3'd1) == PRE_TARGET);
        if (load_s && (state_q == ST_PREAMBLE)) begin
            pre_cnt_d = pre_cnt_q + 3'd1;
            state_d   = (pre_cnt_d == PRE_TARGET) ? ST_RUN : ST_PREAMBLE;
        end else begin
            pre_cnt_d = pre_cnt_q;
            state_d   = state_q;
        end
    end

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            pre_cnt_q <= 3'd0;
            state_q   <= ST_PREAMBLE;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            state_q   <= state_d;
        end
    end
`else
    assign payload_ok_s = 1'b1;
`endif

    // Pop is resolved before push so a full FIFO still accepts on a load edge.
    always_comb begin
        pop_s     = load_s && payload_ok_s && (fifo_count_s != 2'd0);
        ready_s   = (fifo_count_s != 2'd2) || pop_s;
        push_s    = valid_in && ready_s;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (load_s) begin
            shreg_d = pop_s ? fifo_rdata_s : COMMA_BC;
            valid_d = pop_s;
        end else begin
            shreg_d = {shreg_q[BYTE_W-2:0], 1'b0};
            valid_d = valid_q;
        end
    end

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            bit_cnt_q <= 3'd0;
            shreg_q   <= COMMA_BC;
            valid_q   <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            valid_q   <= valid_d;
        end
    end

    fifo_2x8 u_fifo (
        .clk_i   (clk_32f),
        .rst_ni  (reset_L),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i (data_in),
        .rdata_o (fifo_rdata_s),
        .count_o (fifo_count_s)
    );

    assign ready_out = ready_s;
    assign data_out  = shreg_q[BYTE_W-1];
    assign valid_out = valid_q;
    assign frame_out = (bit_cnt_q == 3'd0);
endmodule

// File: tb/tb_paralelo_serial.sv
// Self-checking bench for paralelo_serial: slot-level reference model plus directed literal checks.
module tb_paralelo_serial;
`ifdef PARALELO_SERIAL_PREAMBLE_EN
    localparam int P = 4;
`else
    localparam int P = 1;
`endif

    logic       clk_32f  = 1'b0;
    logic       reset_L  = 1'b0;
    logic       valid_in = 1'b0;
    logic [7:0] data_in  = 8'h00;
    logic       ready_out, data_out, valid_out, frame_out;

    int checks = 0;
    int errors = 0;

    always #5 clk_32f = ~clk_32f;

    paralelo_serial #(.PREAMBLE_BC(4)) dut (
        .clk_32f   (clk_32f),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .frame_out (frame_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: slot n = n-th byte time since reset; slots below P are commas, later slots take the queue head.
    int         m_cyc;
    logic [7:0] m_q[$];
    logic [7:0] m_byte;
    logic       m_valid;
    logic [7:0] rx_q[$];
    int         rx_start[$];
    logic [7:0] rx_sh;
    int         rx_cur;

    initial begin
        int  b, qs;
        bit  pop_now, m_ready;
        forever begin
            @(negedge clk_32f);
            if (!reset_L) begin
                m_cyc = 0;
                m_q.delete();
                m_byte  = 8'hBC;
                m_valid = 1'b0;
            end
            b       = m_cyc % 8;
            qs      = m_q.size();
            pop_now = (b == 7) && ((m_cyc / 8) + 1 >= P) && (qs > 0);
            m_ready = (qs - (pop_now ? 1 : 0)) < 2;
            chk("model_data_out",  data_out,  m_byte[7-b]);
            chk("model_valid_out", valid_out, m_valid);
            chk("model_frame_out", frame_out, b == 0);
            chk("model_ready_out", ready_out, m_ready);
            if (reset_L) begin
                if (valid_out) begin
                    if (frame_out) rx_cur = m_cyc;
                    rx_sh = {rx_sh[6:0], data_out};
                    if (b == 7) begin
                        rx_q.push_back(rx_sh);
                        rx_start.push_back(rx_cur);
                    end
                end
                if (b == 7) begin
                    if (pop_now) begin
                        m_byte  = m_q.pop_front();
                        m_valid = 1'b1;
                    end else begin
                        m_byte  = 8'hBC;
                        m_valid = 1'b0;
                    end
                end
                if (valid_in && m_ready) m_q.push_back(data_in);
                m_cyc++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_32f);
            #1;
        end
    endtask

    task automatic do_reset();
        valid_in = 1'b0;
        reset_L  = 1'b0;
        tick(3);
        reset_L  = 1'b1;
    endtask

    // Push one byte at cycle push_cyc after reset; it must occupy slot P exactly.
    task automatic payload_case(input string name, input logic [7:0] val, input int push_cyc);
        logic [7:0] sh;
        int         early_valid, late_all;
        do_reset();
        early_valid = 0;
        late_all    = 1;
        sh          = 8'h00;
        for (int c = 0; c < 8*P + 9; c++) begin
            valid_in = (c == push_cyc);
            data_in  = val;
            if (c < 8*P && valid_out) early_valid++;
            if (c >= 8*P && c < 8*P + 8) begin
                sh = {sh[6:0], data_out};
                if (!valid_out) late_all = 0;
            end
            if (c == 8*P + 8) chk({name, "_valid_after"}, valid_out, 1'b0);
            tick(1);
        end
        valid_in = 1'b0;
        chk({name, "_commas_only"}, early_valid, 0);
        chk({name, "_byte"}, sh, val);
        chk({name, "_valid_span"}, late_all, 1);
    endtask

    initial begin
        logic [7:0] sh;
        logic [7:0] vals [4];
        int         acc_edge [4];
        int         exp_edge [4];
        int         vacc, ferr, e, guard;
        bit         acc, saw_low, found;

        vals     = '{8'h01, 8'h02, 8'h03, 8'hFF};
        exp_edge = '{0, 1, 7, 15};

        // Reset idle
        reset_L = 1'b0;
        tick(3);
        chk("reset_data_out",  data_out,  1'b1);
        chk("reset_valid_out", valid_out, 1'b0);
        chk("reset_frame_out", frame_out, 1'b1);
        chk("reset_ready_out", ready_out, 1'b1);
        reset_L = 1'b1;
        vacc = 0;
        ferr = 0;
        sh   = 8'h00;
        for (int k = 0; k < 64; k++) begin
            sh = {sh[6:0], data_out};
            if (valid_out) vacc++;
            if (frame_out !== (k % 8 == 0)) ferr++;
            if (k % 8 == 7) chk("idle_byte", sh, 8'hBC);
            tick(1);
        end
        chk("idle_valid", vacc, 0);
        chk("idle_frame", ferr, 0);

        payload_case("preamble_5a", 8'h5A, 2);
        payload_case("first_slot_3c", 8'h3C, 0);

        // Back-to-back stream starting on a byte boundary in RUN
        do_reset();
        tick(8*P + 8);
        chk("b2b_aligned", frame_out, 1'b1);
        rx_q.delete();
        rx_start.delete();
        saw_low = 1'b0;
        e = 0;
        for (int i = 0; i < 4; i++) begin
            data_in  = vals[i];
            valid_in = 1'b1;
            acc      = 1'b0;
            guard    = 0;
            while (!acc && guard < 40) begin
                acc = ready_out;
                if (!ready_out) saw_low = 1'b1;
                tick(1);
                e++;
                guard++;
            end
            if (!acc) chk("b2b_accept_timeout", guard, 0);
            acc_edge[i] = e - 1;
            if (i >= 2) chk("b2b_full_after_swap", ready_out, 1'b0);
        end
        valid_in = 1'b0;
        for (int i = 0; i < 4; i++) chk("b2b_accept_edge", acc_edge[i], exp_edge[i]);
        chk("b2b_ready_dropped", saw_low, 1'b1);
        tick(48);
        chk("b2b_rx_count", rx_q.size(), 4);
        if (rx_q.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("b2b_rx_byte", rx_q[i], vals[i]);
            for (int i = 1; i < 4; i++) chk("b2b_no_gap", rx_start[i] - rx_start[i-1], 8);
        end

        // Reset in the middle of 0xA5 while 0x77 waits in the FIFO
        do_reset();
        tick(8*P + 8);
        data_in  = 8'hA5;
        valid_in = 1'b1;
        tick(1);
        data_in  = 8'h77;
        tick(1);
        valid_in = 1'b0;
        found = 1'b0;
        guard = 0;
        while (!found && guard < 24) begin
            found = valid_out && frame_out;
            if (!found) tick(1);
            guard++;
        end
        chk("midreset_a5_started", found, 1'b1);
        tick(4);
        chk("midreset_a5_bit4", data_out, 1'b0);
        reset_L = 1'b0;
        #1;
        chk("midreset_data_out",  data_out,  1'b1);
        chk("midreset_valid_out", valid_out, 1'b0);
        chk("midreset_frame_out", frame_out, 1'b1);
        chk("midreset_ready_out", ready_out, 1'b1);
        tick(2);
        reset_L = 1'b1;
        vacc = 0;
        sh   = 8'h00;
        for (int k = 0; k < 8*P + 16; k++) begin
            sh = {sh[6:0], data_out};
            if (valid_out) vacc++;
            if (k % 8 == 7) chk("midreset_comma", sh, 8'hBC);
            tick(1);
        end
        chk("midreset_fifo_flushed", vacc, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end, checks %0d", checks);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/paralelo_serial.md
# paralelo_serial

Parallel-to-serial transmit stage that feeds `serial_paralelo`. It accepts 8-bit bytes through a valid/ready handshake and buffers them in a 2-entry FIFO. Each byte is shifted out MSB-first, one bit per `clk_32f` cycle. When no payload is available it transmits the comma byte 0xBC, so the downstream `BC_contador` can lock and raise `active_output`.

## Interface
Parameters:
- `PREAMBLE_BC`, default 4: number of forced comma bytes after reset (range 1–7).

Ports:
- `clk_32f`  in  1: bit clock; one serial bit per rising edge.
- `reset_L`  in  1: reset, asynchronous, active-low.
- `data_in`  in  8: payload byte.
- `valid_in`  in  1: `data_in` is valid; accepted when `valid_in & ready_out`.
- `ready_out`  out  1: FIFO not full.
- `data_out`  out  1: serial bit stream to `serial_paralelo.data_input`.
- `valid_out`  out  1: high for all 8 bit-times of a payload byte; low during comma bytes.
- `frame_out`  out  1: high during bit 0 (MSB) of every byte.

## Operation
- **FIFO (2×8):**
  - Push on `valid_in & ready_out`.
  - Pop only at a byte load.
  - A push and a pop in the same cycle are both performed, including when the FIFO is full: pop happens first, so `ready_out` for that cycle uses the post-pop count.
- **Bit counter:** `bit_cnt` is 3 bits, counts 0..7 and wraps 7→0.
- **Shifter:** 8-bit `shreg`; `data_out = shreg[7]`. Each cycle with `bit_cnt != 7` it shifts left by 1.
- **Byte load** (at the edge where `bit_cnt == 7`):
  - If `pre_cnt == PREAMBLE_BC` and the FIFO is non-empty: pop into `shreg`, next `valid_out = 1`.
  - Otherwise: load 8'hBC, next `valid_out = 0`.
- **State machine:**
  - PREAMBLE: `pre_cnt` increments at each load. Transition to RUN when it reaches `PREAMBLE_BC`. `valid_in` is still accepted into the FIFO, but no pop occurs.
  - RUN: normal load rule above. No exit except reset.
- `frame_out = (bit_cnt == 0)`.
- A payload byte equal to 0xBC is sent as-is with `valid_out = 1`. Disambiguating it is the receiver's concern.

## Timing
- **Reset values** (immediate on `reset_L` low):
  - `bit_cnt = 0`, `shreg = 8'hBC`, so `data_out = 1`.
  - `valid_out = 0`, `frame_out = 1`.
  - FIFO empty, so `ready_out = 1`.
  - `pre_cnt = 0`, state PREAMBLE.
- The first comma byte occupies the first 8 cycles after reset release and counts toward the preamble.
- **Latency in RUN, empty FIFO:** a byte accepted at edge k appears on `data_out` starting at the first `bit_cnt == 0` after the load edge. Worst case is 8 cycles plus 8 to drain.
- **Throughput:** one byte per 8 cycles. With continuous `valid_in`, `ready_out` drops once 2 entries are queued and rises on the next pop edge.
- **Reset mid-byte:** the partial byte is abandoned, FIFO contents are discarded, and the preamble restarts.

## Configuration
- `PARALELO_SERIAL_PREAMBLE_EN`
  - Defined: PREAMBLE state and `PREAMBLE_BC` behave as above.
  - Undefined: the block resets directly into RUN, so the first load may carry payload. `pre_cnt` and its logic are not built.

## Structure
- **Shared package/include:** `COMMA_BC = 8'hBC`, `BYTE_W = 8`, `BIT_CNT_W = 3`, state encodings `ST_PREAMBLE` and `ST_RUN`.
- **One sub-module:** `fifo_2x8`, a 2-entry, 8-bit FIFO with a count output and async active-low reset.
- The shifter, bit counter and state machine stay in `paralelo_serial`.

## Test plan
- **Reset idle:** hold `valid_in = 0` for 64 cycles after reset → `data_out` repeats 1,0,1,1,1,1,0,0; `valid_out = 0` throughout; `frame_out` pulses every 8 cycles.
- **Preamble gating:** push 0x5A at cycle 2 after reset → exactly 4 comma bytes, then 0x5A (0,1,0,1,1,0,1,0) with `valid_out = 1` for those 8 cycles; an attached `serial_paralelo` reaches `BC_contador == 4` and `active_output == 1`.
- **Back-to-back:** stream 0x01, 0x02, 0x03, 0xFF with `valid_in` held high → `ready_out` low after 2 entries queue; bytes emerge in order with no comma gaps.
- **Simultaneous push/pop when full:** FIFO full, `valid_in = 1` on the load edge → one pop and one push; the count stays 2 and no byte is lost.
- **Reset mid-byte:** assert `reset_L = 0` at `bit_cnt == 4` while 0xA5 is shifting → `data_out = 1` immediately, FIFO empty, and the 4-byte preamble restarts after release.
- **Macro off:** build without `PARALELO_SERIAL_PREAMBLE_EN`, push 0x3C at cycle 0 → 0x3C is transmitted in the second byte slot with `valid_out = 1`.
